// File: rtl/mac_sequencer.sv
// mac_sequencer
//
// Sequences one dot product on an external accumulate-only MAC (En, Clr,
// Ain, Bin -> Cout). A start request captures the vector length. The MAC
// is then cleared, and one A/B operand pair is fed per joint handshake.
// The sequencer waits for the last accumulation to land and offers the
// result on a valid/ready port.
//
// Ports
//   clk, rst                  single rising-edge clock, synchronous active-high reset
//   start, len                job request (sampled only in IDLE) and pair count
//   busy                      high whenever the sequencer is not IDLE
//   a_valid/a_data/a_ready    A operand stream
//   b_valid/b_data/b_ready    B operand stream (popped together with A)
//   mac_en, mac_a, mac_b      registered MAC En / Ain / Bin
//   mac_clr                   MAC Clr, high only in CLEAR
//   mac_cout                  MAC Cout (3*DATA_WIDTH, wraps inside the MAC)
//   res_valid/res_data/res_ready  result port
//   stall_cnt                 STREAM stall counter, or 0 when the feature is off
//
// Optional feature macro: MAC_SEQ_STALL_CNT_EN builds the stall counter.
// Without it, stall_cnt is tied to zero.

module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    input  logic                      a_valid,
    input  logic [DATA_WIDTH-1:0]     a_data,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [DATA_WIDTH-1:0]     b_data,
    output logic                      b_ready,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic [DATA_WIDTH-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]     mac_b,
    input  logic [3*DATA_WIDTH-1:0]   mac_cout,
    output logic                      res_valid,
    output logic [3*DATA_WIDTH-1:0]   res_data,
    input  logic                      res_ready,
    output logic [15:0]               stall_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } state_e;

    state_e                    state_q, state_d;
    logic [LEN_WIDTH-1:0]      rem_q, rem_d;
    logic                      drain_q, drain_d;
    logic                      mac_en_q, mac_en_d;
    logic [DATA_WIDTH-1:0]     mac_a_q, mac_a_d;
    logic [DATA_WIDTH-1:0]     mac_b_q, mac_b_d;
    logic                      res_valid_q, res_valid_d;
    logic [3*DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic                      fire;
    logic                      clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            drain_q     <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            drain_q     <= drain_d;
            mac_en_q    <= mac_en_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        drain_d     = drain_q;
        mac_en_d    = 1'b0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        fire        = 1'b0;
        clr         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                drain_d = 1'b0;
                state_d = (rem_q != '0) ? STREAM : DRAIN;
            end
            STREAM: begin
                // Both streams are popped in the same cycle, or neither is.
                fire = a_valid & b_valid & (rem_q != '0);
                if (fire) begin
                    mac_a_d  = a_data;
                    mac_b_d  = b_data;
                    mac_en_d = 1'b1;
                    rem_d    = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // First cycle: the last registered En reaches the MAC.
                // Second cycle: Cout has absorbed it and can be captured.
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    drain_d     = 1'b0;
                    res_data_d  = mac_cout;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign a_ready   = fire;
    assign b_ready   = fire;
    assign mac_clr   = clr;
    assign mac_en    = mac_en_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Counts STREAM cycles that still owe pairs but see no joint handshake.
    // The counter saturates rather than wraps.
    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (state_q == STREAM && rem_q != '0 && !fire && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int RW = 3 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          a_valid, b_valid;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          mac_en, mac_clr;
    logic [DW-1:0] mac_a, mac_b;
    logic [RW-1:0] cout;
    logic          res_valid;
    logic [RW-1:0] res_data;
    logic          res_ready;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    mac_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_cout  (cout),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .stall_cnt (stall_cnt)
    );

    // External accumulate-only MAC; starts with junk so a missing clear shows up.
    initial cout = 24'h5A5A5A;
    always @(posedge clk) begin
        if (mac_clr)     cout <= '0;
        else if (mac_en) cout <= cout + RW'(mac_a) * RW'(mac_b);
    end

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] aq[$];
    logic [DW-1:0] bq[$];
    bit a_gate = 1'b0, b_gate = 1'b0, rr = 1'b0;
    bit hs_a = 1'b0, hs_b = 1'b0, hs_r = 1'b0;
    int a_pops = 0, b_pops = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: retire last edge's handshakes, drive inputs at the
    // falling edge, then note which handshakes the coming rising edge takes.
    task automatic step(input bit st, input bit rs);
        @(negedge clk);
        if (hs_a) begin aq.delete(0); a_pops++; end
        if (hs_b) begin bq.delete(0); b_pops++; end
        if (hs_a || hs_b) check_eq("pair_pop", 64'(hs_a), 64'(hs_b));
        rst       = rs;
        start     = st;
        res_ready = rr;
        a_valid   = !rs && a_gate && (aq.size() > 0);
        b_valid   = !rs && b_gate && (bq.size() > 0);
        a_data    = a_valid ? aq[0] : DW'($urandom);
        b_data    = b_valid ? bq[0] : DW'($urandom);
        #2;
        hs_a = a_valid && a_ready;
        hs_b = b_valid && b_ready;
        hs_r = res_valid && res_ready;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"},    64'(busy),      0);
        check_eq({tag, "_a_ready"}, 64'(a_ready),   0);
        check_eq({tag, "_b_ready"}, 64'(b_ready),   0);
        check_eq({tag, "_mac_en"},  64'(mac_en),    0);
        check_eq({tag, "_mac_clr"}, 64'(mac_clr),   0);
        check_eq({tag, "_mac_a"},   64'(mac_a),     0);
        check_eq({tag, "_mac_b"},   64'(mac_b),     0);
        check_eq({tag, "_res_vld"}, 64'(res_valid), 0);
        check_eq({tag, "_res_dat"}, 64'(res_data),  0);
        check_eq({tag, "_stall"},   64'(stall_cnt), 0);
    endtask

    // rnd: random per-cycle stream gating; bdel: cycles after start before B
    // may be valid; rdy_delay: cycles res_valid waits for res_ready;
    // spam: extra start pulses while busy; fixed: known answer, or -1.
    task automatic run_job(input int n, input bit rnd, input int bdel, input int rdy_delay,
                           input bit spam, input longint fixed);
        logic [RW-1:0] exp;
        int  k, lat, seen_cnt, exp_stall;
        bit  seen, done;
        exp = '0;
        seen = 1'b0; done = 1'b0; seen_cnt = 0; exp_stall = 0; lat = -1;
        while (aq.size() < n) aq.push_back(DW'($urandom));
        while (bq.size() < n) bq.push_back(DW'($urandom));
        for (int i = 0; i < n; i++) exp += RW'(aq[i]) * RW'(bq[i]);
        a_pops = 0; b_pops = 0;
        len    = LW'(n);
        rr     = (rdy_delay == 0);
        a_gate = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        b_gate = rnd ? ($urandom_range(0, 3) != 0) : (bdel == 0);
        step(1'b1, 1'b0);
        for (k = 1; k < 4000 && !done; k++) begin
            a_gate = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            b_gate = rnd ? ($urandom_range(0, 3) != 0) : (k >= bdel);
            rr     = (rdy_delay == 0) || (seen_cnt >= rdy_delay);
            step(spam && k >= 2 && ($urandom_range(0, 1) == 1), 1'b0);
            check_eq("busy_job", 64'(busy), 1);
            if (k >= 2 && a_pops < n && !(a_valid && b_valid)) exp_stall++;
            if (res_valid && !seen) begin
                seen = 1'b1;
                lat  = k - 1;
                check_eq("res_data", 64'(res_data), 64'(exp));
                if (fixed >= 0) check_eq("res_known", 64'(res_data), 64'(fixed));
                if (!rnd && bdel == 0) check_eq("latency", 64'(lat), 64'(n + 3));
            end else if (seen) begin
                check_eq("res_hold_vld", 64'(res_valid), 1);
                check_eq("res_hold_dat", 64'(res_data), 64'(exp));
            end
            if (seen) seen_cnt++;
            if (hs_r) begin
                rr = 1'b0;
                step(1'b0, 1'b0);
                check_eq("res_vld_clr", 64'(res_valid), 0);
                check_eq("busy_clr", 64'(busy), 0);
                done = 1'b1;
            end
        end
        if (!done) check_eq("job_timeout", 0, 1);
        check_eq("a_pops", 64'(a_pops), 64'(n));
        check_eq("b_pops", 64'(b_pops), 64'(n));
`ifdef MAC_SEQ_STALL_CNT_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`else
        check_eq("stall_cnt", 64'(stall_cnt), 0);
`endif
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; len = '0; res_ready = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_zero("reset");
        step(1'b0, 1'b0);

        aq = '{8'd1, 8'd2, 8'd3};
        bq = '{8'd4, 8'd5, 8'd6};
        run_job(3, 1'b0, 0, 0, 1'b0, 32);

        run_job(0, 1'b0, 0, 0, 1'b0, 0);

        for (int i = 0; i < 4; i++) begin aq.push_back(8'd255); bq.push_back(8'd255); end
        run_job(4, 1'b0, 0, 0, 1'b0, 260100);
        for (int i = 0; i < 255; i++) begin aq.push_back(8'd255); bq.push_back(8'd255); end
        run_job(255, 1'b0, 0, 0, 1'b0, 16581375);

        aq = '{8'd7, 8'd9};
        bq.delete();
        run_job(2, 1'b0, 5, 5, 1'b0, -1);

        // Reset part-way through a five-pair job.
        for (int i = 0; i < 5; i++) begin aq.push_back(DW'($urandom)); bq.push_back(DW'($urandom)); end
        a_pops = 0; len = 8'd5; a_gate = 1'b1; b_gate = 1'b1; rr = 1'b1;
        step(1'b1, 1'b0);
        for (int i = 0; i < 20 && a_pops < 2; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_zero("midrst");
        aq.delete(); bq.delete();
        aq.push_back(8'd3); bq.push_back(8'd3);
        run_job(1, 1'b0, 0, 0, 1'b0, 9);

        run_job(6, 1'b0, 0, 2, 1'b1, -1);

        for (int j = 0; j < 25; j++) begin
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 10));
            for (int e = 0; e < int'($urandom_range(0, 2)); e++) aq.push_back(DW'($urandom));
            for (int e = 0; e < int'($urandom_range(0, 2)); e++) bq.push_back(DW'($urandom));
            run_job(n, 1'b1, 0, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
